draw_write_scheduler: RTL and testbench

//   Single owner of the draw framebuffer write port (draw_addr_write/draw_data_in/draw_we).

---
 rtl/draw_write_scheduler_if.sv | 35 +++
 rtl/draw_write_scheduler.sv | 120 ++++++++++++
 tb/tb_draw_write_scheduler.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/draw_write_scheduler_if.sv
// Request/response bundle between the pixel sources and the framebuffer write scheduler.
// "master" is the requester side; "slave" is the scheduler that owns the write port.
interface draw_write_scheduler_if #(
  parameter int unsigned DRAW_WIDTH  = 640,
  parameter int unsigned DRAW_HEIGHT = 480,
  parameter int unsigned DRAW_DATAW  = 1,
  parameter int unsigned XW          = $clog2(DRAW_WIDTH),
  parameter int unsigned YW          = $clog2(DRAW_HEIGHT)
);
  localparam int unsigned DRAW_SIZE  = DRAW_WIDTH * DRAW_HEIGHT;
  localparam int unsigned DRAW_ADDRW = $clog2(DRAW_SIZE);

  logic                  clear_start;
  logic                  clear_busy;
  logic                  clear_done;
  logic                  pt_valid;
  logic                  pt_ready;
  logic [XW-1:0]         pt_x;
  logic [YW-1:0]         pt_y;
  logic [DRAW_DATAW-1:0] pt_data;
  logic [DRAW_ADDRW-1:0] draw_addr_write;
  logic [DRAW_DATAW-1:0] draw_data_in;
  logic                  draw_we;
  logic [15:0]           drop_cnt;

  modport master (
    output clear_start, pt_valid, pt_x, pt_y, pt_data,
    input  clear_busy, clear_done, pt_ready, draw_addr_write, draw_data_in, draw_we, drop_cnt
  );

  modport slave (
    input  clear_start, pt_valid, pt_x, pt_y, pt_data,
    output clear_busy, clear_done, pt_ready, draw_addr_write, draw_data_in, draw_we, drop_cnt
  );
endinterface

// File: rtl/draw_write_scheduler.sv
// Sole owner of the draw framebuffer write port: arbitrates a full-frame clear sweep
// against a stream of (x, y, data) point plots, one write per cycle.
module draw_write_scheduler #(
  parameter int unsigned DRAW_WIDTH  = 640,
  parameter int unsigned DRAW_HEIGHT = 480,
  parameter int unsigned DRAW_DATAW  = 1,
  parameter logic [DRAW_DATAW-1:0] CLEAR_VAL = '0,
  parameter int unsigned XW          = $clog2(DRAW_WIDTH),
  parameter int unsigned YW          = $clog2(DRAW_HEIGHT)
) (
  input  logic                          clk,
  input  logic                          rst,
  draw_write_scheduler_if.slave         bus
);
  localparam int unsigned DRAW_SIZE  = DRAW_WIDTH * DRAW_HEIGHT;
  localparam int unsigned DRAW_ADDRW = $clog2(DRAW_SIZE);
  localparam logic [DRAW_ADDRW-1:0] LAST_ADDR = DRAW_ADDRW'(DRAW_SIZE - 1);
  localparam logic [DRAW_ADDRW-1:0] ROW_STEP  = DRAW_ADDRW'(DRAW_WIDTH);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state, state_d;
  logic [DRAW_ADDRW-1:0] cnt, cnt_d, cnt_nxt;
  logic [DRAW_ADDRW-1:0] addr_q, addr_d;
  logic [DRAW_DATAW-1:0] data_q, data_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [15:0]           drop_q, drop_d;

  logic                  ready_c;
  logic                  accept;
  logic                  on_screen;
  logic [DRAW_ADDRW-1:0] pt_addr;

  // Compare at 32 bits so a power-of-two width still has a representable off-screen range.
  assign on_screen = (32'(bus.pt_x) < DRAW_WIDTH) && (32'(bus.pt_y) < DRAW_HEIGHT);
  assign pt_addr   = DRAW_ADDRW'(bus.pt_y) * ROW_STEP + DRAW_ADDRW'(bus.pt_x);
  assign cnt_nxt   = cnt + DRAW_ADDRW'(1);

  assign ready_c = (state == IDLE) && !bus.clear_start;
  assign accept  = bus.pt_valid && ready_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      drop_q <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      we_q   <= we_d;
      busy_q <= busy_d;
      done_q <= done_d;
      drop_q <= drop_d;
    end
  end

  // Next-state and next-output logic; address/data hold on idle cycles.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    drop_d  = drop_q;
    case (state)
      IDLE: begin
        if (bus.clear_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
          we_d    = 1'b1;
          addr_d  = '0;
          data_d  = CLEAR_VAL;
          busy_d  = 1'b1;
          done_d  = (LAST_ADDR == '0);
        end else if (accept) begin
          if (on_screen) begin
            we_d   = 1'b1;
            addr_d = pt_addr;
            data_d = bus.pt_data;
          end else if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
          end
        end
      end
      CLEAR: begin
        // cnt is the address currently presented; leave once the last one has been shown.
        if (cnt == LAST_ADDR) begin
          state_d = IDLE;
        end else begin
          cnt_d  = cnt_nxt;
          we_d   = 1'b1;
          addr_d = cnt_nxt;
          data_d = CLEAR_VAL;
          busy_d = 1'b1;
          done_d = (cnt_nxt == LAST_ADDR);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.pt_ready        = ready_c;
  assign bus.draw_we         = we_q;
  assign bus.draw_addr_write = addr_q;
  assign bus.draw_data_in    = data_q;
  assign bus.clear_busy      = busy_q;
  assign bus.clear_done      = done_q;
  assign bus.drop_cnt        = drop_q;
endmodule

// File: tb/tb_draw_write_scheduler.sv
// Directed bench for draw_write_scheduler on an 8x4 frame: point table, drop saturation,
// clear sweep, clear/point collision, mid-sweep reset and back-to-back point streaming.
module tb_draw_write_scheduler;
  localparam int unsigned W  = 8;
  localparam int unsigned H  = 4;
  localparam int unsigned XW = 4;
  localparam int unsigned YW = 3;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  draw_write_scheduler_if #(.DRAW_WIDTH(W), .DRAW_HEIGHT(H), .DRAW_DATAW(1), .XW(XW), .YW(YW)) bus ();

  draw_write_scheduler #(
    .DRAW_WIDTH(W), .DRAW_HEIGHT(H), .DRAW_DATAW(1), .CLEAR_VAL(1'b0), .XW(XW), .YW(YW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          d;
    logic          exp_ready;
    logic          exp_we;
    logic [4:0]    exp_addr;
    logic          exp_data;
    logic [15:0]   exp_drop;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pt(input logic v, input int x, input int y, input logic d);
    bus.pt_valid = v;
    bus.pt_x     = XW'(x);
    bus.pt_y     = YW'(y);
    bus.pt_data  = d;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    bus.clear_start = 1'b0;
    drive_pt(1'b0, 0, 0, 1'b0);

    //               v     x     y     d     rdy   we    addr   data  drop
    tbl[0] = '{1'b1, 4'd3, 3'd2, 1'b1, 1'b1, 1'b1, 5'd19, 1'b1, 16'd0};
    tbl[1] = '{1'b1, 4'd8, 3'd0, 1'b0, 1'b1, 1'b0, 5'd19, 1'b1, 16'd1};
    tbl[2] = '{1'b1, 4'd0, 3'd4, 1'b0, 1'b1, 1'b0, 5'd19, 1'b1, 16'd2};
    tbl[3] = '{1'b1, 4'd7, 3'd3, 1'b0, 1'b1, 1'b1, 5'd31, 1'b0, 16'd2};
    tbl[4] = '{1'b1, 4'd0, 3'd0, 1'b1, 1'b1, 1'b1, 5'd0,  1'b1, 16'd2};
    tbl[5] = '{1'b0, 4'd5, 3'd1, 1'b0, 1'b1, 1'b0, 5'd0,  1'b1, 16'd2};
    tbl[6] = '{1'b1, 4'd15,3'd7, 1'b0, 1'b1, 1'b0, 5'd0,  1'b1, 16'd3};

    step();
    step();
    chk("rst_we",   32'(bus.draw_we), 32'd0);
    chk("rst_addr", 32'(bus.draw_addr_write), 32'd0);
    chk("rst_data", 32'(bus.draw_data_in), 32'd0);
    chk("rst_busy", 32'(bus.clear_busy), 32'd0);
    chk("rst_done", 32'(bus.clear_done), 32'd0);
    chk("rst_drop", 32'(bus.drop_cnt), 32'd0);
    rst = 1'b0;

    // Point table
    for (int i = 0; i < 7; i++) begin
      drive_pt(tbl[i].v, int'(tbl[i].x), int'(tbl[i].y), tbl[i].d);
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(bus.pt_ready), 32'(tbl[i].exp_ready));
      step();
      chk($sformatf("tbl%0d_we", i),   32'(bus.draw_we), 32'(tbl[i].exp_we));
      chk($sformatf("tbl%0d_addr", i), 32'(bus.draw_addr_write), 32'(tbl[i].exp_addr));
      chk($sformatf("tbl%0d_data", i), 32'(bus.draw_data_in), 32'(tbl[i].exp_data));
      chk($sformatf("tbl%0d_drop", i), 32'(bus.drop_cnt), 32'(tbl[i].exp_drop));
    end

    // Drop counter saturation: 3 + 65532 = 65535, then 8 more must stick
    drive_pt(1'b1, 8, 0, 1'b0);
    for (int i = 0; i < 65532; i++) @(posedge clk);
    #1;
    chk("drop_at_max", 32'(bus.drop_cnt), 32'h0000FFFF);
    for (int i = 0; i < 8; i++) @(posedge clk);
    #1;
    chk("drop_sat", 32'(bus.drop_cnt), 32'h0000FFFF);
    chk("drop_no_we", 32'(bus.draw_we), 32'd0);
    drive_pt(1'b0, 0, 0, 1'b0);

    // Clear sweep
    bus.clear_start = 1'b1;
    #1;
    chk("clr_ready_start", 32'(bus.pt_ready), 32'd0);
    step();
    bus.clear_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("clr%0d_we", i),    32'(bus.draw_we), 32'd1);
      chk($sformatf("clr%0d_addr", i),  32'(bus.draw_addr_write), 32'(i));
      chk($sformatf("clr%0d_data", i),  32'(bus.draw_data_in), 32'd0);
      chk($sformatf("clr%0d_busy", i),  32'(bus.clear_busy), 32'd1);
      chk($sformatf("clr%0d_done", i),  32'(bus.clear_done), (i == 31) ? 32'd1 : 32'd0);
      chk($sformatf("clr%0d_ready", i), 32'(bus.pt_ready), 32'd0);
      step();
    end
    chk("clr_end_we",    32'(bus.draw_we), 32'd0);
    chk("clr_end_busy",  32'(bus.clear_busy), 32'd0);
    chk("clr_end_done",  32'(bus.clear_done), 32'd0);
    chk("clr_end_ready", 32'(bus.pt_ready), 32'd1);
    chk("clr_end_addr",  32'(bus.draw_addr_write), 32'd31);

    // Clear wins over simultaneous point; re-pulse mid-sweep is ignored
    bus.clear_start = 1'b1;
    drive_pt(1'b1, 2, 1, 1'b1);
    #1;
    chk("col_ready", 32'(bus.pt_ready), 32'd0);
    step();
    bus.clear_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("col%0d_we", i),   32'(bus.draw_we), 32'd1);
      chk($sformatf("col%0d_addr", i), 32'(bus.draw_addr_write), 32'(i));
      chk($sformatf("col%0d_data", i), 32'(bus.draw_data_in), 32'd0);
      bus.clear_start = (i == 5);
      step();
    end
    bus.clear_start = 1'b0;
    #1;
    chk("col_post_we",    32'(bus.draw_we), 32'd0);
    chk("col_post_ready", 32'(bus.pt_ready), 32'd1);
    step();
    drive_pt(1'b0, 0, 0, 1'b0);
    chk("col_pt_we",   32'(bus.draw_we), 32'd1);
    chk("col_pt_addr", 32'(bus.draw_addr_write), 32'd10);
    chk("col_pt_data", 32'(bus.draw_data_in), 32'd1);
    step();
    chk("col_pt_once", 32'(bus.draw_we), 32'd0);

    // Reset in the middle of a sweep
    bus.clear_start = 1'b1;
    step();
    bus.clear_start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("mid_addr10", 32'(bus.draw_addr_write), 32'd10);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_we",   32'(bus.draw_we), 32'd0);
    chk("arst_addr", 32'(bus.draw_addr_write), 32'd0);
    chk("arst_data", 32'(bus.draw_data_in), 32'd0);
    chk("arst_busy", 32'(bus.clear_busy), 32'd0);
    chk("arst_drop", 32'(bus.drop_cnt), 32'd0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("post_rst%0d_we", i),    32'(bus.draw_we), 32'd0);
      chk($sformatf("post_rst%0d_busy", i),  32'(bus.clear_busy), 32'd0);
      chk($sformatf("post_rst%0d_ready", i), 32'(bus.pt_ready), 32'd1);
    end

    // Back-to-back point stream
    for (int i = 0; i < 16; i++) begin
      int x, y;
      x = (i * 3) % 8;
      y = i % 4;
      drive_pt(1'b1, x, y, i[0]);
      #1;
      chk($sformatf("strm%0d_ready", i), 32'(bus.pt_ready), 32'd1);
      step();
      chk($sformatf("strm%0d_we", i),   32'(bus.draw_we), 32'd1);
      chk($sformatf("strm%0d_addr", i), 32'(bus.draw_addr_write), 32'(y * 8 + x));
      chk($sformatf("strm%0d_data", i), 32'(bus.draw_data_in), 32'(i[0]));
    end
    drive_pt(1'b0, 0, 0, 1'b0);
    step();
    chk("strm_end_we", 32'(bus.draw_we), 32'd0);
    chk("strm_drop",   32'(bus.drop_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
